// File: rtl/raytracing_pkg.sv
// raytracing_pkg: shared types and defaults for the line scheduler
// and its sphere table.
package raytracing_pkg;

    localparam int PX_Y_OFFSET_D = 240;
    localparam int LINE_W_D      = 640;
    localparam int SPHERE_W      = 64;

    typedef logic [11:0] color_t;

    typedef struct packed {
        logic signed [14:0] x;
        logic signed [14:0] y;
        logic [15:0]        z;
        logic [5:0]         r;
        color_t             color;
    } sphere_t;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LATCH,
        S_SQUARE,
        S_LAUNCH,
        S_WAIT_START,
        S_RENDER,
        S_COMMIT
    } state_t;

endpackage

// File: rtl/sphere_shadow_table.sv
// sphere_shadow_table: double-buffered sphere storage; the SPI side
// writes the shadow copy, a latch strobe freezes it into the live copy.
module sphere_shadow_table
    import raytracing_pkg::*;
#(
    parameter int N_SPHERES = 4,
    parameter int IDX_W     = $clog2(N_SPHERES)
) (
    input  logic                          CLK100MHZ,
    input  logic                          ck_rst_,
    input  logic                          upd_valid,
    input  logic [IDX_W-1:0]              upd_index,
    input  logic [SPHERE_W-1:0]           upd_data,
    input  logic                          latch,
    output logic [N_SPHERES*SPHERE_W-1:0] sphere_live,
    output logic [N_SPHERES-1:0][5:0]     live_r,
    output logic [N_SPHERES-1:0]          sphere_valid
);

    sphere_t shadow [N_SPHERES];
    sphere_t live   [N_SPHERES];

    // live copies the pre-write shadow, so a write in the latch cycle
    // only shows up on the following pass
    always_ff @(posedge CLK100MHZ) begin
        if (!ck_rst_) begin
            for (int k = 0; k < N_SPHERES; k++) begin
                shadow[k] <= '0;
                live[k]   <= '0;
            end
        end else begin
            if (upd_valid)
                shadow[upd_index] <= sphere_t'(upd_data);
            if (latch)
                for (int k = 0; k < N_SPHERES; k++)
                    live[k] <= shadow[k];
        end
    end

    always_comb begin
        sphere_live  = '0;
        live_r       = '0;
        sphere_valid = '0;
        for (int k = 0; k < N_SPHERES; k++) begin
            sphere_live[k*SPHERE_W +: SPHERE_W] = live[k];
            live_r[k]       = live[k].r;
            sphere_valid[k] = |live[k].r;
        end
    end

endmodule

// File: rtl/raytracing_line_scheduler.sv
// raytracing_line_scheduler: runs one render pass per VGA line request
// and commits the worker buffer into the displayed line register.
module raytracing_line_scheduler
    import raytracing_pkg::*;
#(
    parameter int LINE_W        = LINE_W_D,
    parameter int N_WORKERS     = 10,
    parameter int N_SPHERES     = 4,
    parameter int COLOR_W       = 12,
    parameter int Y_W           = 12,
    parameter int PX_Y_OFFSET   = PX_Y_OFFSET_D,
    parameter int START_TIMEOUT = 64
) (
    input  logic                          CLK100MHZ,
    input  logic                          ck_rst_,
    input  logic                          next_line,
    input  logic [Y_W-1:0]                next_y,
    input  logic                          upd_valid,
    input  logic [$clog2(N_SPHERES)-1:0]  upd_index,
    input  logic [63:0]                   upd_data,
    output logic                          upd_ready,
    output logic                          workers_activate,
    input  logic [N_WORKERS-1:0]          workers_busy,
    output logic [Y_W-1:0]                pixel_y,
    output logic [2*Y_W-1:0]              pixel_y_sqrd,
    output logic [N_SPHERES*64-1:0]       sphere_live,
    output logic [N_SPHERES*12-1:0]       sphere_r_sqrd,
    output logic [N_SPHERES-1:0]          sphere_valid,
    input  logic [LINE_W*COLOR_W-1:0]     worker_line_in,
    output logic [LINE_W*COLOR_W-1:0]     line_out,
    output logic                          line_valid,
    input  logic                          clr_flags,
    output logic                          overrun,
    output logic                          start_timeout
);

    localparam int IDX_W = $clog2(N_SPHERES);
    localparam int TO_W  = $clog2(START_TIMEOUT);

    state_t state, state_nx;

    logic                         line_q;
    logic                         req_q;
    logic [IDX_W-1:0]             sph_cnt;
    logic [TO_W-1:0]              to_cnt;
    logic [N_SPHERES-1:0][5:0]    live_r;
    logic [N_SPHERES-1:0][11:0]   r_sq;
    logic                         any_busy;
    logic                         to_hit;
    logic                         sq_last;
    logic                         ovr_set;
    logic                         to_set;
    logic signed [2*Y_W-1:0]      py_ext;
    logic signed [2*Y_W-1:0]      py_prod;
    logic [5:0]                   r_sel;
    logic [11:0]                  r_prod;

    assign upd_ready     = 1'b1;
    assign sphere_r_sqrd = r_sq;
    assign any_busy      = |workers_busy;
    assign to_hit        = (to_cnt == TO_W'(START_TIMEOUT - 1));
    assign sq_last       = (sph_cnt == IDX_W'(N_SPHERES - 1));
    assign ovr_set       = req_q && (state != S_IDLE);
    assign to_set        = (state == S_WAIT_START) && !any_busy && to_hit;

    assign py_ext  = {{Y_W{pixel_y[Y_W-1]}}, pixel_y};
    assign py_prod = py_ext * py_ext;
    assign r_sel   = live_r[sph_cnt];
    assign r_prod  = {6'b0, r_sel} * {6'b0, r_sel};

    sphere_shadow_table #(
        .N_SPHERES (N_SPHERES),
        .IDX_W     (IDX_W)
    ) u_table (
        .CLK100MHZ    (CLK100MHZ),
        .ck_rst_      (ck_rst_),
        .upd_valid    (upd_valid),
        .upd_index    (upd_index),
        .upd_data     (upd_data),
        .latch        (state == S_LATCH),
        .sphere_live  (sphere_live),
        .live_r       (live_r),
        .sphere_valid (sphere_valid)
    );

    // reset loads the current level so a held request is not an edge
    always_ff @(posedge CLK100MHZ) begin
        if (!ck_rst_) begin
            line_q <= next_line;
            req_q  <= 1'b0;
        end else begin
            line_q <= next_line;
            req_q  <= next_line & ~line_q;
        end
    end

    always_ff @(posedge CLK100MHZ) begin
        if (!ck_rst_)
            state <= S_IDLE;
        else
            state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        unique case (state)
            S_IDLE:       if (req_q) state_nx = S_LATCH;
            S_LATCH:      state_nx = S_SQUARE;
            S_SQUARE:     if (sq_last) state_nx = S_LAUNCH;
            S_LAUNCH:     state_nx = S_WAIT_START;
            S_WAIT_START: begin
                if (any_busy)
                    state_nx = S_RENDER;
                else if (to_hit)
                    state_nx = S_COMMIT;
            end
            S_RENDER:     if (!any_busy) state_nx = S_COMMIT;
            S_COMMIT:     state_nx = S_IDLE;
            default:      state_nx = S_IDLE;
        endcase
    end

    always_ff @(posedge CLK100MHZ) begin
        if (!ck_rst_) begin
            pixel_y          <= '0;
            pixel_y_sqrd     <= '0;
            r_sq             <= '0;
            sph_cnt          <= '0;
            to_cnt           <= '0;
            workers_activate <= 1'b0;
            line_out         <= '0;
            line_valid       <= 1'b0;
        end else begin
            line_valid <= 1'b0;
            case (state)
                S_LATCH: begin
                    pixel_y <= next_y - Y_W'(PX_Y_OFFSET);
                    sph_cnt <= '0;
                end
                S_SQUARE: begin
                    if (sph_cnt == '0)
                        pixel_y_sqrd <= py_prod;
                    r_sq[sph_cnt] <= r_prod;
                    sph_cnt       <= sph_cnt + IDX_W'(1);
                end
                S_LAUNCH: begin
                    workers_activate <= 1'b1;
                    to_cnt           <= '0;
                end
                S_WAIT_START: to_cnt <= to_cnt + TO_W'(1);
                S_COMMIT: begin
                    line_out         <= worker_line_in;
                    line_valid       <= 1'b1;
                    workers_activate <= 1'b0;
                end
                default: ;
            endcase
        end
    end

    // a set event in the same cycle as clr_flags keeps the flag
    always_ff @(posedge CLK100MHZ) begin
        if (!ck_rst_) begin
            overrun       <= 1'b0;
            start_timeout <= 1'b0;
        end else begin
            if (ovr_set)
                overrun <= 1'b1;
            else if (clr_flags)
                overrun <= 1'b0;
            if (to_set)
                start_timeout <= 1'b1;
            else if (clr_flags)
                start_timeout <= 1'b0;
        end
    end

endmodule

// File: tb/tb_raytracing_line_scheduler.sv
// tb_raytracing_line_scheduler: randomized passes checked against a
// transaction-level model of the sphere table, squares and pass timing.
module tb_raytracing_line_scheduler;

    localparam int LW  = 640;
    localparam int NW  = 10;
    localparam int NS  = 4;
    localparam int CW  = 12;
    localparam int YW  = 12;
    localparam int OFS = 240;
    localparam int TO  = 64;
    localparam int LB  = LW * CW;

    localparam int M_NORM = 0;
    localparam int M_OVR  = 1;
    localparam int M_TO   = 2;
    localparam int M_RST  = 3;

    logic            CLK100MHZ = 1'b0;
    logic            ck_rst_ = 1'b0;
    logic            next_line = 1'b0;
    logic [YW-1:0]   next_y = '0;
    logic            upd_valid = 1'b0;
    logic [1:0]      upd_index = '0;
    logic [63:0]     upd_data = '0;
    logic            upd_ready;
    logic            workers_activate;
    logic [NW-1:0]   workers_busy = '0;
    logic [YW-1:0]   pixel_y;
    logic [2*YW-1:0] pixel_y_sqrd;
    logic [NS*64-1:0] sphere_live;
    logic [NS*12-1:0] sphere_r_sqrd;
    logic [NS-1:0]   sphere_valid;
    logic [LB-1:0]   worker_line_in = '0;
    logic [LB-1:0]   line_out;
    logic            line_valid;
    logic            clr_flags = 1'b0;
    logic            overrun;
    logic            start_timeout;

    raytracing_line_scheduler dut (
        .CLK100MHZ        (CLK100MHZ),
        .ck_rst_          (ck_rst_),
        .next_line        (next_line),
        .next_y           (next_y),
        .upd_valid        (upd_valid),
        .upd_index        (upd_index),
        .upd_data         (upd_data),
        .upd_ready        (upd_ready),
        .workers_activate (workers_activate),
        .workers_busy     (workers_busy),
        .pixel_y          (pixel_y),
        .pixel_y_sqrd     (pixel_y_sqrd),
        .sphere_live      (sphere_live),
        .sphere_r_sqrd    (sphere_r_sqrd),
        .sphere_valid     (sphere_valid),
        .worker_line_in   (worker_line_in),
        .line_out         (line_out),
        .line_valid       (line_valid),
        .clr_flags        (clr_flags),
        .overrun          (overrun),
        .start_timeout    (start_timeout)
    );

    always #5 CLK100MHZ = ~CLK100MHZ;

    int n_cmp = 0;
    int n_bad = 0;
    logic [63:0] shadow_m [NS];
    logic [LB-1:0] last_line;

    task automatic chk(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge CLK100MHZ);
        #1;
    endtask

    function automatic int px_bad(input logic [LB-1:0] a,
                                  input logic [LB-1:0] b);
        int n = 0;
        for (int p = 0; p < LW; p++)
            if (a[p*CW +: CW] !== b[p*CW +: CW]) n++;
        return n;
    endfunction

    function automatic logic [63:0] mk_sphere(input logic [5:0] r);
        logic [14:0] x = 15'($urandom);
        logic [14:0] y = 15'($urandom);
        logic [15:0] z = 16'($urandom);
        logic [11:0] c = 12'($urandom);
        return {x, y, z, r, c};
    endfunction

    task automatic fill_line(input bit abc);
        for (int p = 0; p < LW; p++)
            worker_line_in[p*CW +: CW] = abc ? 12'hABC : CW'($urandom);
    endtask

    task automatic wr_sphere(input int idx, input logic [63:0] d);
        upd_valid = 1'b1;
        upd_index = 2'(idx);
        upd_data  = d;
        step();
        upd_valid = 1'b0;
        shadow_m[idx] = d;
    endtask

    task automatic commit_checks();
        chk("line_valid", 64'(line_valid), 1);
        chk("act_fall", 64'(workers_activate), 0);
        chk("line_out_px", px_bad(line_out, worker_line_in), 0);
        last_line = worker_line_in;
        fill_line(1'b0);
        step();
        chk("lv_pulse_end", 64'(line_valid), 0);
        chk("line_hold_px", px_bad(line_out, last_line), 0);
    endtask

    task automatic run_pass(input logic [YW-1:0] y, input int lw_idx,
                            input logic [63:0] lw_data, input int mode,
                            input int busy_at, input int busy_len,
                            input bit abc);
        logic [63:0]   snap [NS];
        logic [YW-1:0] ey;
        logic [NS-1:0] ev;
        int e;
        int r;
        int pys;
        int cnt;
        next_y    = y;
        next_line = 1'b1;
        step();
        e = 0;
        next_line = 1'b0;
        step();
        e = 1;
        for (int k = 0; k < NS; k++) snap[k] = shadow_m[k];
        if (lw_idx >= 0) begin
            upd_valid = 1'b1;
            upd_index = 2'(lw_idx);
            upd_data  = lw_data;
        end
        step();
        e = 2;
        upd_valid = 1'b0;
        if (lw_idx >= 0) shadow_m[lw_idx] = lw_data;
        ey = y - YW'(OFS);
        chk("pixel_y", 64'(pixel_y), 64'(ey));
        while (!workers_activate && e < 20) begin
            step();
            e++;
        end
        chk("act_latency", 64'(e), 64'(3 + NS));
        pys = int'($signed(ey));
        chk("pixel_y_sqrd", 64'(pixel_y_sqrd), 64'(pys * pys));
        ev = '0;
        for (int k = 0; k < NS; k++) begin
            r = int'(snap[k][17:12]);
            ev[k] = (r != 0);
            chk($sformatf("r_sqrd%0d", k), 64'(sphere_r_sqrd[k*12 +: 12]),
                64'(r * r));
            chk($sformatf("live%0d", k), sphere_live[k*64 +: 64], snap[k]);
        end
        chk("sphere_valid", 64'(sphere_valid), 64'(ev));
        fill_line(abc);
        if (mode == M_TO) begin
            repeat (TO - 1) step();
            chk("to_early", 64'(start_timeout), 0);
            chk("lv_early", 64'(line_valid), 0);
            clr_flags = 1'b1;
            step();
            clr_flags = 1'b0;
            chk("to_set_wins", 64'(start_timeout), 1);
            step();
            commit_checks();
            chk("to_sticky", 64'(start_timeout), 1);
            clr_flags = 1'b1;
            step();
            clr_flags = 1'b0;
            chk("to_cleared", 64'(start_timeout), 0);
            return;
        end
        repeat (busy_at) step();
        for (int i = 0; i < busy_len; i++) begin
            workers_busy = NW'($urandom) | NW'(1 << $urandom_range(0, NW - 1));
            if (mode == M_OVR && i == 1) next_line = 1'b1;
            if (mode == M_OVR && i == 2) next_line = 1'b0;
            step();
        end
        if (mode == M_RST) begin
            ck_rst_ = 1'b0;
            step();
            ck_rst_ = 1'b1;
            workers_busy = '0;
            chk("rst_act", 64'(workers_activate), 0);
            chk("rst_pixel_y", 64'(pixel_y), 0);
            chk("rst_valid", 64'(sphere_valid), 0);
            cnt = 0;
            repeat (30) begin
                step();
                cnt += int'(line_valid) + int'(workers_activate);
            end
            chk("rst_no_commit", 64'(cnt), 0);
            for (int k = 0; k < NS; k++) shadow_m[k] = '0;
            last_line = '0;
            chk("rst_line_out_px", px_bad(line_out, last_line), 0);
            return;
        end
        if (mode == M_OVR) begin
            chk("overrun_set", 64'(overrun), 1);
            chk("ovr_line_hold_px", px_bad(line_out, last_line), 0);
        end
        workers_busy = '0;
        step();
        chk("lv_before", 64'(line_valid), 0);
        step();
        commit_checks();
        if (mode == M_OVR) begin
            cnt = 0;
            repeat (15) begin
                step();
                cnt += int'(workers_activate);
            end
            chk("no_extra_pass", 64'(cnt), 0);
            chk("overrun_sticky", 64'(overrun), 1);
            clr_flags = 1'b1;
            step();
            clr_flags = 1'b0;
            chk("overrun_cleared", 64'(overrun), 0);
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int cnt;
        int li;
        for (int k = 0; k < NS; k++) shadow_m[k] = '0;
        last_line = '0;
        ck_rst_   = 1'b0;
        next_line = 1'b1;
        repeat (3) step();
        chk("rst_upd_ready", 64'(upd_ready), 1);
        chk("rst_act", 64'(workers_activate), 0);
        chk("rst_line_valid", 64'(line_valid), 0);
        chk("rst_overrun", 64'(overrun), 0);
        chk("rst_timeout", 64'(start_timeout), 0);
        chk("rst_pixel_y", 64'(pixel_y), 0);
        chk("rst_py_sqrd", 64'(pixel_y_sqrd), 0);
        chk("rst_valid", 64'(sphere_valid), 0);
        chk("rst_r_sqrd", 64'(sphere_r_sqrd), 0);
        chk("rst_line_out_px", px_bad(line_out, last_line), 0);
        ck_rst_ = 1'b1;
        cnt = 0;
        repeat (20) begin
            step();
            cnt += int'(workers_activate);
        end
        chk("held_level_no_pass", 64'(cnt), 0);
        next_line = 1'b0;
        repeat (2) step();

        wr_sphere(3, mk_sphere(6'd6));
        run_pass(12'd0, 2, mk_sphere(6'd5), M_NORM, 5, 100, 1'b1);
        chk("tp_py_sqrd", 64'(pixel_y_sqrd), 57600);
        chk("tp_rsq3", 64'(sphere_r_sqrd[3*12 +: 12]), 36);
        chk("tp_valid1", 64'(sphere_valid), 64'(4'b1000));
        run_pass(12'(480), -1, '0, M_NORM, 0, 1, 1'b0);
        chk("tp_rsq2", 64'(sphere_r_sqrd[2*12 +: 12]), 25);
        chk("tp_valid2", 64'(sphere_valid), 64'(4'b1100));

        run_pass(12'($urandom), -1, '0, M_OVR, 3, 20, 1'b0);
        run_pass(12'($urandom), -1, '0, M_TO, 0, 0, 1'b0);
        run_pass(12'($urandom), 0, mk_sphere(6'h3F), M_NORM, 63, 4, 1'b0);
        run_pass(12'($urandom), -1, '0, M_RST, 2, 10, 1'b0);
        run_pass(12'($urandom), -1, '0, M_NORM, 1, 3, 1'b0);

        for (int it = 0; it < 8; it++) begin
            repeat ($urandom_range(0, 3))
                wr_sphere($urandom_range(0, NS - 1),
                          mk_sphere(6'($urandom_range(0, 3) == 0 ? 0 : $urandom)));
            li = ($urandom_range(0, 1) == 1) ? $urandom_range(0, NS - 1) : -1;
            run_pass(12'($urandom), li, mk_sphere(6'($urandom)), M_NORM,
                     $urandom_range(0, TO - 1), $urandom_range(1, 40), 1'b0);
            repeat ($urandom_range(0, 4)) step();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/raytracing_line_scheduler.md
Name: raytracing_line_scheduler

Overview:
- Parametrised successor of the line-level raytracing controller.
- Sequences one render pass per VGA line request: latches the line Y, snapshots a double-buffered sphere table and precomputes squares. It then launches the worker array, waits for completion and commits the finished line to the VGA line register.
- Sits between the SPI receiver (sphere updates), the worker array and the VGA timing block.

Parameters:
- LINE_W, 640, pixels per line (= N_WORKERS * jobs per worker).
- N_WORKERS, 10, worker count; width of the busy vector.
- N_SPHERES, 4, sphere table depth.
- COLOR_W, 12, bits per pixel colour.
- Y_W, 12, signed pixel-Y width.
- PX_Y_OFFSET, 240, subtracted from next_y to centre pixel_y.
- START_TIMEOUT, 64, cycles allowed for any worker to assert busy after launch.

Ports:
- CLK100MHZ  in  1  system clock.
- ck_rst_  in  1  synchronous active-low reset.
- next_line  in  1  VGA line request (level); a rising edge starts a pass.
- next_y  in  Y_W  line number accompanying next_line.
- upd_valid  in  1  sphere write strobe.
- upd_index  in  clog2(N_SPHERES)  target table entry.
- upd_data  in  64  packed sphere record.
- upd_ready  out  1  write accepted this cycle.
- workers_activate  out  1  start level to all workers.
- workers_busy  in  N_WORKERS  per-worker busy.
- pixel_y  out  Y_W  signed centred Y for the current pass.
- pixel_y_sqrd  out  2*Y_W  pixel_y squared, unsigned.
- sphere_live  out  N_SPHERES*64  frozen table for workers.
- sphere_r_sqrd  out  N_SPHERES*12  per-sphere radius squared.
- sphere_valid  out  N_SPHERES  live entry has r != 0.
- worker_line_in  in  LINE_W*COLOR_W  interleaved worker buffer.
- line_out  out  LINE_W*COLOR_W  committed line to VGA.
- line_valid  out  1  one-cycle pulse on commit.
- clr_flags  in  1  clears sticky flags.
- overrun  out  1  sticky: request arrived while busy.
- start_timeout  out  1  sticky: workers never started.

Behaviour:
- Reset values:
  - All outputs 0 except upd_ready = 1.
  - Shadow and live tables 0; state IDLE.
  - Edge-detect register is loaded with the current next_line value, so a level held across reset does not start a pass.
- Sphere record layout:
  - x[63:49] signed, y[48:34] signed, z[33:18] unsigned, r[17:12] unsigned, colour[11:0].
- Sphere writes:
  - upd_ready is always 1.
  - A write lands in the shadow entry upd_index the cycle after the strobe.
  - The live table changes only in LATCH.
  - A write in the same cycle as LATCH is not in this pass; it is visible from the next pass.
- State machine: IDLE -> LATCH -> SQUARE -> LAUNCH -> WAIT_START -> RENDER -> COMMIT -> IDLE.
  - IDLE: on a next_line rising edge (registered edge detect), go to LATCH next cycle.
  - LATCH: pixel_y <= next_y - PX_Y_OFFSET (Y_W wrap); live <= shadow; sphere counter <= 0.
  - SQUARE: one shared multiplier, one sphere per cycle, sphere_r_sqrd[k] <= r*r (6x6 -> 12 bits). pixel_y_sqrd is written in the first SQUARE cycle. Duration is exactly N_SPHERES cycles.
  - LAUNCH: workers_activate <= 1; timeout counter <= 0.
  - WAIT_START: any workers_busy bit -> RENDER. If the counter reaches START_TIMEOUT-1 first, set start_timeout and go to COMMIT.
  - RENDER: when all workers_busy bits are 0 -> COMMIT.
  - COMMIT: line_out <= worker_line_in; line_valid = 1 for one cycle; workers_activate <= 0; -> IDLE.
- Latency: next_line edge sampled at cycle t puts workers_activate high at t+3+N_SPHERES.
- Overrun: a next_line rising edge outside IDLE sets overrun and the request is dropped. line_out holds the previous line.
- Flags: clr_flags clears both sticky flags. If it coincides with a set event, the set wins.
- Reset mid-pass: ck_rst_ low returns to IDLE on that edge, deasserts workers_activate and does not commit.

Decomposition:
- raytracing_pkg holds: sphere_t packed struct with field widths, color_t, state enum, and default PX_Y_OFFSET/LINE_W constants.
- One sub-module, sphere_shadow_table: owns the shadow/live arrays, the write port, the latch strobe and the sphere_valid decode.
- The scheduler FSM, multiplier and line register stay in raytracing_line_scheduler.

Test Plan:
- Reset with next_line held high, then release -> no pass starts. Drive next_y=0, next_line edge -> pixel_y = -240, pixel_y_sqrd = 57600, workers_activate rises exactly 7 cycles after the edge (N_SPHERES=4).
- Write sphere 3 with r=6 before the edge, and sphere 2 with r=5 during LATCH -> pass shows sphere_r_sqrd[3]=36 and sphere_valid=4'b1000. The next pass shows sphere_r_sqrd[2]=25 and sphere_valid=4'b1100.
- Workers busy for 100 cycles, worker_line_in = pattern 0xABC per pixel -> line_out equals the pattern, line_valid is a single-cycle pulse, workers_activate falls.
- Second next_line edge during RENDER -> overrun=1, no extra pass, line_out unchanged. Assert clr_flags -> overrun=0.
- Workers never assert busy -> start_timeout=1 after 64 cycles, then COMMIT. The scheduler accepts the next request.
- Pull ck_rst_ low mid-RENDER for one cycle -> state IDLE, workers_activate=0, line_valid never pulses.
